timer_counter: RTL and testbench

Programmable 32-bit down-counting timer that sits directly downstream of the system bridge as device TC0 (word window 0x7F00–0x7F0B) or TC1 (0x7F10–0x7F1B). It takes the bridge's per-device write enable, low address bits and write data, returns read data for the bridge's read mux, and drives the device interrupt line that the bridge folds into HWInt. Two instances are built, one per window.

---
 rtl/timer_counter_if.sv | 28 ++
 rtl/timer_counter.sv | 144 ++++++++++++++
 tb/tb_timer_counter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/timer_counter_if.sv
// Bus-side port bundle for timer_counter: the bridge drives the word
// select, write enable and write data; the timer returns read data and
// its interrupt line.
interface timer_counter_if;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        IRQ;

  // Bridge side
  modport master (
    output Addr,
    output WE,
    output WD,
    input  RD,
    input  IRQ
  );

  // Timer side
  modport slave (
    input  Addr,
    input  WE,
    input  WD,
    output RD,
    output IRQ
  );
endinterface

// File: rtl/timer_counter.sv
// timer_counter: programmable 32-bit down-counting timer (TC0/TC1).
// Register map by word select: 0 = CTRL {IM, Mode[1:0], Enable},
// 1 = PRESET, 2 = COUNT (read-only), 3 = reads 0.
// Optional feature macro: TIMER_IRQ_MASK_EN. When defined, CTRL[3] (IM)
// is stored and gates IRQ; otherwise IRQ follows the internal irq flag.
module timer_counter (
  input  logic           clk,
  input  logic           reset_n,
  timer_counter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] MODE_RELOAD = 2'd1;

  state_t      state_r;
  logic        enable_r;
  logic [1:0]  mode_r;
  logic [31:0] preset_r;
  logic [31:0] count_r;
  logic        irq_r;

  logic        wr_ctrl_s;
  logic        wr_preset_s;
  logic        count_last_s;
  logic        irq_set_s;
  logic        reload_clr_s;
  logic        im_s;
  logic [31:0] rd_s;

`ifdef TIMER_IRQ_MASK_EN
  logic        im_r;
  assign im_s    = im_r;
  assign bus.IRQ = im_r & irq_r;
`else
  // IM is not stored: it reads back as 0 and does not gate IRQ.
  assign im_s    = 1'b0;
  assign bus.IRQ = irq_r;
`endif

  assign wr_ctrl_s    = bus.WE & (bus.Addr == ADDR_CTRL);
  assign wr_preset_s  = bus.WE & (bus.Addr == ADDR_PRESET);
  // COUNT of 0 or 1 both terminate, so PRESET = 0 acts like PRESET = 1
  // and the counter never wraps.
  assign count_last_s = (count_r <= 32'd1);
  assign irq_set_s    = (state_r == CNT) & enable_r & count_last_s;
  assign reload_clr_s = (state_r == INT) & (mode_r == MODE_RELOAD);

  // Timer FSM plus register file; bus writes are ordered after the FSM so
  // a CTRL write in the INT cycle overrides the one-shot Enable clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      enable_r <= 1'b0;
      mode_r   <= 2'd0;
      preset_r <= 32'd0;
      count_r  <= 32'd0;
      irq_r    <= 1'b0;
`ifdef TIMER_IRQ_MASK_EN
      im_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (enable_r) begin
            state_r <= LOAD;
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD: begin
          count_r <= preset_r;
          state_r <= CNT;
        end
        CNT: begin
          if (!enable_r) begin
            state_r <= IDLE;
          end else if (count_last_s) begin
            count_r <= 32'd0;
            state_r <= INT;
          end else begin
            count_r <= count_r - 32'd1;
          end
        end
        INT: begin
          if (mode_r == MODE_RELOAD) begin
            state_r <= LOAD;
          end else begin
            enable_r <= 1'b0;
            state_r  <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase

      // Setting the flag wins over a same-cycle software clear.
      if (irq_set_s) begin
        irq_r <= 1'b1;
      end else if (wr_ctrl_s || wr_preset_s) begin
        irq_r <= 1'b0;
      end else if (reload_clr_s) begin
        irq_r <= 1'b0;
      end else begin
        irq_r <= irq_r;
      end

      if (wr_ctrl_s) begin
        enable_r <= bus.WD[0];
        mode_r   <= bus.WD[2:1];
`ifdef TIMER_IRQ_MASK_EN
        im_r     <= bus.WD[3];
`endif
      end

      if (wr_preset_s) begin
        preset_r <= bus.WD;
      end
    end
  end

  // Zero-latency read mux over the current register values.
  always_comb begin
    rd_s = 32'd0;
    case (bus.Addr)
      ADDR_CTRL:   rd_s = {28'd0, im_s, mode_r, enable_r};
      ADDR_PRESET: rd_s = preset_r;
      ADDR_COUNT:  rd_s = count_r;
      default:     rd_s = 32'd0;
    endcase
  end

  assign bus.RD = rd_s;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: expectations are queued when a check
// is requested and popped when the DUT output is sampled.
module tb_timer_counter;

  logic clk = 1'b0;
  logic reset_n;

  timer_counter_if bus ();

  timer_counter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

`ifdef TIMER_IRQ_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   pass_cnt  = 0;
  int   fail_cnt  = 0;
  int   total_cnt = 0;

  // CTRL as software should read it back.
  function automatic logic [31:0] ctrl_view(input logic [31:0] v);
    if (MASK_EN) ctrl_view = {28'd0, v[3:0]};
    else         ctrl_view = {29'd0, v[2:0]};
  endfunction

  // IRQ pin given IM and the internal flag.
  function automatic logic irq_view(input logic im, input logic flag);
    if (MASK_EN) irq_view = im & flag;
    else         irq_view = flag;
  endfunction

  task automatic compare(input logic [31:0] obs);
    exp_t e;
    total_cnt++;
    if (sb_q.size() == 0) begin
      fail_cnt++;
      $error("FAIL scoreboard_empty: observed 0x%08h expected <none>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) pass_cnt++;
      else begin
        fail_cnt++;
        $error("FAIL %s: observed 0x%08h expected 0x%08h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    sb_q.push_back('{tag, exp});
    bus.Addr = a;
    #1;
    compare(bus.RD);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    sb_q.push_back('{tag, {31'd0, exp}});
    #1;
    compare({31'd0, bus.IRQ});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.Addr = a;
    bus.WD   = d;
    bus.WE   = 1'b1;
    @(posedge clk);
    #1;
    bus.WE   = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    bus.WE   = 1'b0;
    bus.Addr = 2'd0;
    bus.WD   = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    for (int a = 0; a < 4; a++) chk_rd("reset_rd", 2'(a), 32'd0);
    chk_irq("reset_irq", 1'b0);
    reset_n = 1'b1;
    tick(1);

    // One-shot, PRESET = 5
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    tick(2);
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) tick(1);
      chk_rd("os_count", 2'd2, 32'(5 - k));
      chk_irq("os_irq", (k == 5));
    end
    tick(1);
    chk_rd("os_ctrl_after", 2'd0, ctrl_view(32'h8));
    chk_irq("os_irq_hold", 1'b1);
    wr(2'd0, 32'h8);
    chk_irq("os_irq_clr", 1'b0);

    // Auto-reload, PRESET = 3: pulse every 5 cycles
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      chk_irq("ar_irq", (k >= 5) && ((k - 5) % 5 == 0));
      if (k == 7 || k == 12) chk_rd("ar_reload", 2'd2, 32'd3);
    end
    wr(2'd0, 32'h8);
    tick(3);

    // Disable mid-count, then write COUNT, then re-enable
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h9);
    tick(8);
    chk_rd("dis_count_pre", 2'd2, 32'd94);
    wr(2'd0, 32'h8);
    chk_rd("dis_count_edge", 2'd2, 32'd93);
    tick(1);
    chk_rd("dis_count_frozen", 2'd2, 32'd93);
    wr(2'd2, 32'h0000_1234);
    chk_rd("count_wr_ignored", 2'd2, 32'd93);
    tick(3);
    chk_rd("dis_count_still", 2'd2, 32'd93);
    chk_irq("dis_irq", 1'b0);
    wr(2'd0, 32'h9);
    tick(2);
    chk_rd("reen_reload", 2'd2, 32'd100);
    wr(2'd0, 32'h8);
    tick(2);

    // PRESET = 0 behaves like 1: IRQ 3 cycles after the write
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 3; k++) begin
      tick(1);
      chk_irq("p0_irq", (k == 3));
    end
    tick(1);
    wr(2'd0, 32'h8);
    chk_irq("p0_irq_clr", 1'b0);

    // Addr 3 and CTRL upper bits
    wr(2'd3, 32'hFFFF_FFFF);
    chk_rd("addr3_rd", 2'd3, 32'd0);
    wr(2'd0, 32'hFFFF_FFF1);
    chk_rd("ctrl_upper", 2'd0, 32'h1);
    wr(2'd0, 32'h0);
    tick(3);

    // PRESET write in the cycle irq is set: set wins
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    tick(3);
    wr(2'd1, 32'd2);
    chk_irq("set_wins", 1'b1);
    tick(1);
    chk_rd("set_wins_ctrl", 2'd0, ctrl_view(32'h8));
    wr(2'd0, 32'h8);
    chk_irq("set_wins_clr", 1'b0);

    // CTRL write in the INT cycle overrides the Enable clear
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    tick(4);
    chk_irq("mask_irq", irq_view(1'b0, 1'b1));
    wr(2'd0, 32'h9);
    chk_rd("ovr_ctrl", 2'd0, ctrl_view(32'h9));
    chk_irq("ovr_irq_clr", 1'b0);
    tick(2);
    chk_rd("ovr_restart", 2'd2, 32'd2);
    wr(2'd0, 32'h8);
    tick(2);

    // Mask: one-shot with IM = 0
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    tick(5);
    chk_irq("mask_done_irq", irq_view(1'b0, 1'b1));
    chk_rd("mask_ctrl", 2'd0, 32'h0);
    chk_rd("mask_count", 2'd2, 32'd0);
    wr(2'd0, 32'h8);
    chk_irq("mask_clr_irq", 1'b0);
    chk_rd("mask_ctrl_im", 2'd0, ctrl_view(32'h8));

    // Asynchronous reset mid-count
    wr(2'd1, 32'd50);
    wr(2'd0, 32'h9);
    tick(12);
    chk_rd("rst_pre_count", 2'd2, 32'd40);
    reset_n = 1'b0;
    for (int a = 0; a < 4; a++) chk_rd("rst_async_rd", 2'(a), 32'd0);
    chk_irq("rst_async_irq", 1'b0);
    #1;
    reset_n = 1'b1;
    tick(5);
    chk_rd("rst_idle_count", 2'd2, 32'd0);
    chk_rd("rst_idle_ctrl", 2'd0, 32'd0);
    chk_irq("rst_idle_irq", 1'b0);
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    tick(2);
    chk_rd("rst_restart", 2'd2, 32'd3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
